// File: rtl/circuit2_seq_sched_if.sv
// Requester-side handshake and result bus for circuit2_seq_sched.
// The requester drives start/a/b/c; the scheduler returns busy/done/x/z.
interface circuit2_seq_sched_if #(
  parameter int DATAWIDTH = 32
);
  logic                        start;
  logic signed [DATAWIDTH-1:0] a;
  logic signed [DATAWIDTH-1:0] b;
  logic signed [DATAWIDTH-1:0] c;
  logic                        busy;
  logic                        done;
  logic signed [DATAWIDTH-1:0] x;
  logic signed [DATAWIDTH-1:0] z;

  modport master (output start, a, b, c, input busy, done, x, z);
  modport slave  (input start, a, b, c, output busy, done, x, z);
endinterface

// File: rtl/circuit2_seq_sched.sv
// Multi-cycle circuit2 scheduler: one shared add/sub unit, compare, mux, shift.
// Optional CIRCUIT2_SEQ_ABORT_EN adds an 'abort' input that returns the FSM to IDLE.
module circuit2_seq_sched #(
  parameter int DATAWIDTH = 32
) (
  input logic clk,
  input logic rst,
`ifdef CIRCUIT2_SEQ_ABORT_EN
  input logic abort,
`endif
  circuit2_seq_sched_if.slave bus
);
  localparam int W = DATAWIDTH;

  typedef enum logic [2:0] {IDLE, ADD_AB, ADD_AC, SUB_AB, CMP, OUT} state_t;

  state_t              state;
  logic signed [W-1:0] ra, rb, rc;
  logic signed [W-1:0] d, e, f, g, h;
  logic signed [W-1:0] x_r, z_r;
  logic                lt, eq;
  logic                busy_r, done_r;
  logic                abort_req;

`ifdef CIRCUIT2_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Shared adder/subtractor; op select and operand mux decode state only.
  logic         alu_sub;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;
  assign alu_sub = (state == SUB_AB);
  assign alu_b   = (state == ADD_AC) ? rc : rb;
  assign alu_y   = ra + (alu_sub ? ~alu_b : alu_b) + {{(W-1){1'b0}}, alu_sub};

  // CMP-cycle combinational decisions; g feeds h in the same cycle.
  logic                lt_c, eq_c;
  logic signed [W-1:0] g_c, h_c;
  assign lt_c = (d < e);
  assign eq_c = (d == e);
  assign g_c  = lt_c ? d : e;
  assign h_c  = eq_c ? g_c : f;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rc     <= '0;
      d      <= '0;
      e      <= '0;
      f      <= '0;
      g      <= '0;
      h      <= '0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      x_r    <= '0;
      z_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort_req && state != IDLE) begin
        state  <= IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              ra     <= bus.a;
              rb     <= bus.b;
              rc     <= bus.c;
              busy_r <= 1'b1;
              state  <= ADD_AB;
            end
          end
          ADD_AB: begin
            d     <= alu_y;
            state <= ADD_AC;
          end
          ADD_AC: begin
            e     <= alu_y;
            state <= SUB_AB;
          end
          SUB_AB: begin
            f     <= alu_y;
            state <= CMP;
          end
          CMP: begin
            lt    <= lt_c;
            eq    <= eq_c;
            g     <= g_c;
            h     <= h_c;
            state <= OUT;
          end
          OUT: begin
            x_r    <= g << lt;
            z_r    <= h >>> eq;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.x    = x_r;
  assign bus.z    = z_r;
endmodule

// File: tb/tb_circuit2_seq_sched.sv
// Scoreboard bench for circuit2_seq_sched: expected x/z queued at issue, popped on done.
module tb_circuit2_seq_sched;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  circuit2_seq_sched_if #(.DATAWIDTH(W)) bus ();
`ifdef CIRCUIT2_SEQ_ABORT_EN
  logic abort = 1'b0;
  circuit2_seq_sched #(.DATAWIDTH(W)) dut (.clk(clk), .rst(rst), .abort(abort), .bus(bus));
`else
  circuit2_seq_sched #(.DATAWIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] z;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Reference: d/e/f, signed compare, mux, then 0/1-bit shifts written as slices.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic signed [W-1:0] d, e, f, g, h;
    logic lt, eq;
    exp_t r;
    d  = a + b;
    e  = a + c;
    f  = a - b;
    lt = (d < e);
    eq = (d == e);
    g  = lt ? d : e;
    h  = eq ? g : f;
    r.x = lt ? {g[W-2:0], 1'b0} : g;
    r.z = eq ? {h[W-1], h[W-1:1]} : h;
    return r;
  endfunction

  // One-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input exp_t ex);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    sb.push_back(ex);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges (current one = 1) until done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20 && cyc < 0; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.done === 1'b1) cyc = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    total++; if (bus.x !== '0) $display("FAIL reset_x got %h want 0", bus.x); else passed++;
    total++; if (bus.z !== '0) $display("FAIL reset_z got %h want 0", bus.z); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start_busy got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_basic();
    logic [W-1:0] va[8], vb[8], vc[8];
    exp_t ex, got;
    int   cyc;
    logic [W-1:0] held_x;
    va[0] = 5;             vb[0] = 3;            vc[0] = 1;
    va[1] = 1;             vb[1] = 2;            vc[1] = 5;
    va[2] = 4;             vb[2] = 2;            vc[2] = 2;
    va[3] = 32'h7FFFFFFF;  vb[3] = 1;            vc[3] = 0;
    va[4] = 32'h80000000;  vb[4] = 32'hFFFFFFFF; vc[4] = 32'h7FFFFFFF;
    for (int i = 5; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vc[i] = $urandom;
    end
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: ex = '{x: 32'd6, z: 32'd2};
        1: ex = '{x: 32'd6, z: 32'hFFFFFFFF};
        2: ex = '{x: 32'd6, z: 32'd3};
        3: ex = '{x: 32'h00000000, z: 32'h7FFFFFFE};
        default: ex = model(va[i], vb[i], vc[i]);
      endcase
      issue(va[i], vb[i], vc[i], ex);
      total++; if (bus.busy !== 1'b1) $display("FAIL op%0d_busy_after_start got %b want 1", i, bus.busy); else passed++;
      wait_done(cyc);
      total++; if (cyc !== 6) $display("FAIL op%0d_latency got %0d want 6", i, cyc); else passed++;
      got = sb.pop_front();
      total++; if (bus.x !== got.x) $display("FAIL op%0d_x got %h want %h", i, bus.x, got.x); else passed++;
      total++; if (bus.z !== got.z) $display("FAIL op%0d_z got %h want %h", i, bus.z, got.z); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL op%0d_busy_at_done got %b want 0", i, bus.busy); else passed++;
      held_x = got.x;
      @(negedge clk);
      total++; if (bus.done !== 1'b0) $display("FAIL op%0d_done_one_cycle got %b want 0", i, bus.done); else passed++;
      total++; if (bus.x !== held_x) $display("FAIL op%0d_x_hold got %h want %h", i, bus.x, held_x); else passed++;
    end
  endtask

  task automatic test_ignore_busy();
    exp_t got;
    int   cyc;
    int   extra;
    issue(5, 3, 1, '{x: 32'd6, z: 32'd2});
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    total++; if (cyc !== 4) $display("FAIL busy_start_latency got %0d want 4", cyc); else passed++;
    got = sb.pop_front();
    total++; if (bus.x !== got.x) $display("FAIL busy_start_x got %h want %h", bus.x, got.x); else passed++;
    total++; if (bus.z !== got.z) $display("FAIL busy_start_z got %h want %h", bus.z, got.z); else passed++;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    total++; if (extra !== 0) $display("FAIL busy_start_no_queue got %0d active cycles want 0", extra); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t got;
    int   cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 1; bus.b = 2; bus.c = 5;
    sb.push_back(model(1, 2, 5));
    wait_done(cyc);
    total++; if (cyc !== 7) $display("FAIL b2b_first_latency got %0d want 7", cyc); else passed++;
    got = sb.pop_front();
    total++; if (bus.x !== got.x) $display("FAIL b2b_first_x got %h want %h", bus.x, got.x); else passed++;
    total++; if (bus.z !== got.z) $display("FAIL b2b_first_z got %h want %h", bus.z, got.z); else passed++;
    bus.a = 4; bus.b = 2; bus.c = 2;
    sb.push_back(model(4, 2, 2));
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_reaccept_busy got %b want 1", bus.busy); else passed++;
    wait_done(cyc);
    total++; if (cyc !== 6) $display("FAIL b2b_second_latency got %0d want 6", cyc); else passed++;
    got = sb.pop_front();
    total++; if (bus.x !== got.x) $display("FAIL b2b_second_x got %h want %h", bus.x, got.x); else passed++;
    total++; if (bus.z !== got.z) $display("FAIL b2b_second_z got %h want %h", bus.z, got.z); else passed++;
  endtask

  task automatic test_mid_reset();
    exp_t got;
    int   cyc;
    int   extra;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 1; bus.b = 2; bus.c = 5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL midrst_done got %b want 0", bus.done); else passed++;
    total++; if (bus.x !== '0) $display("FAIL midrst_x got %h want 0", bus.x); else passed++;
    total++; if (bus.z !== '0) $display("FAIL midrst_z got %h want 0", bus.z); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    total++; if (extra !== 0) $display("FAIL midrst_idle_after got %0d active cycles want 0", extra); else passed++;
    issue(32'hFFFFFFF0, 32'd7, 32'hFFFFFFF9, model(32'hFFFFFFF0, 32'd7, 32'hFFFFFFF9));
    wait_done(cyc);
    total++; if (cyc !== 6) $display("FAIL midrst_recover_latency got %0d want 6", cyc); else passed++;
    got = sb.pop_front();
    total++; if (bus.x !== got.x) $display("FAIL midrst_recover_x got %h want %h", bus.x, got.x); else passed++;
    total++; if (bus.z !== got.z) $display("FAIL midrst_recover_z got %h want %h", bus.z, got.z); else passed++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
